// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory request/grant/response channel
// plus the valid/ready instruction channel toward decode.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic [6:0]  Op;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        instr_valid;
   logic        instr_ready;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic        flush;
   logic [31:0] flush_pc;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output Instr, Op, PC, PCPlus4, instr_valid,
      input  instr_ready, PCSrc, PCTarget, flush, flush_pc
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  Instr, Op, PC, PCPlus4, instr_valid,
      output instr_ready, PCSrc, PCTarget, flush, flush_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request to a variable-latency
// instruction memory, holds the fetched word for decode, applies redirects/flushes.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n, pc4, instr, instr_n;
   logic        kill, kill_n, valid, valid_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_REQ;
         pc    <= RESET_PC;
         pc4   <= RESET_PC + 32'd4;
         instr <= NOP_INSTR;
         kill  <= 1'b0;
         valid <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         pc4   <= pc_n + 32'd4;
         instr <= instr_n;
         kill  <= kill_n;
         valid <= valid_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr;
      kill_n  = kill;
      valid_n = valid;
      case (state)
         S_REQ: begin
            if (bus.flush) begin
               pc_n = bus.flush_pc & ~32'd3;
               // The granted request still returns data; it belongs to the old stream.
               if (bus.imem_gnt) begin
                  kill_n  = 1'b1;
                  state_n = S_WAIT;
               end
            end else if (bus.imem_gnt) begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rvalid) begin
               if (kill || bus.flush) begin
                  kill_n  = 1'b0;
                  state_n = S_REQ;
                  if (bus.flush) pc_n = bus.flush_pc & ~32'd3;
               end else begin
                  instr_n = bus.imem_rdata;
                  valid_n = 1'b1;
                  state_n = S_HOLD;
               end
            end else if (bus.flush) begin
               pc_n   = bus.flush_pc & ~32'd3;
               kill_n = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.flush) begin
               valid_n = 1'b0;
               instr_n = NOP_INSTR;
               pc_n    = bus.flush_pc & ~32'd3;
               state_n = S_REQ;
            end else if (bus.instr_ready) begin
               valid_n = 1'b0;
               instr_n = NOP_INSTR;
               pc_n    = bus.PCSrc ? (bus.PCTarget & ~32'd3) : pc4;
               state_n = S_REQ;
            end
         end
         default: state_n = S_REQ;
      endcase
   end

   assign bus.imem_req    = (state == S_REQ) && !rst;
   assign bus.imem_addr   = pc;
   assign bus.Instr       = instr;
   assign bus.Op          = instr[6:0];
   assign bus.PC          = pc;
   assign bus.PCPlus4     = pc4;
   assign bus.instr_valid = valid;

endmodule
